gen_ram_wren: RTL and testbench

- Write-side controller for the two-line-buffer (RAM A / RAM B) scheme used by the CCD edge pipeline.
- Accepts the raw CCD pixel stream (valid-qualified) and steers whole rows alternately into RAM A and RAM B: row 0 to A, row 1 to B, and so on.
- Generates the write enables, write address and registered write data.
- Its rama_wren/ramb_wren drive the read-enable generator, which starts reading on the first ramb_wren.

---
 rtl/gen_ram_wren_if.sv | 42 ++++
 rtl/gen_ram_wren.sv | 108 ++++++++++
 tb/tb_gen_ram_wren.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gen_ram_wren_if.sv
`default_nettype none
// ============================================================================
// Module      : gen_ram_wren_if
// Description : Pixel-stream input and line-buffer write-side signals for
//               gen_ram_wren. err_flag exists only when GEN_RAM_WREN_ERR_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface gen_ram_wren_if;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_in;
  logic        rama_wren;
  logic        ramb_wren;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;
  logic        row_parity;
  logic        row_end;
  logic        frame_end;
`ifdef GEN_RAM_WREN_ERR_EN
  logic        err_flag;
`endif

  // Capture side drives the pixel stream and observes the write side.
  modport master (
    output frame_start, pix_valid, pix_in,
    input  rama_wren, ramb_wren, wr_addr, wr_data, row_parity, row_end, frame_end
`ifdef GEN_RAM_WREN_ERR_EN
    , input err_flag
`endif
  );

  // Controller side consumes the pixel stream and drives the write side.
  modport slave (
    input  frame_start, pix_valid, pix_in,
    output rama_wren, ramb_wren, wr_addr, wr_data, row_parity, row_end, frame_end
`ifdef GEN_RAM_WREN_ERR_EN
    , output err_flag
`endif
  );
endinterface
`default_nettype wire

// File: rtl/gen_ram_wren.sv
`default_nettype none
// ============================================================================
// Module      : gen_ram_wren
// Description : Write-side controller for the RAM A / RAM B line buffers.
//               Even rows are written to RAM A, odd rows to RAM B. Outputs
//               are registered one cycle behind the accepted pixel.
//               Optional macro GEN_RAM_WREN_ERR_EN adds a sticky err_flag.
// Revision    : 1.0  initial release
// ============================================================================
module gen_ram_wren #(
  parameter int COLUMN_SIZE = 1280,
  parameter int ROW_SIZE    = 1024
) (
  input  wire logic       clk,
  input  wire logic       aclr,
  gen_ram_wren_if.slave   bus
);

  localparam logic [10:0] LAST_PIX = 11'(COLUMN_SIZE - 1);
  localparam logic [10:0] LAST_ROW = 11'(ROW_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] count_pixel;
  logic [10:0] count_row;

  // Row-steering FSM with the write enables, address and data registered
  // alongside it; frame_start has priority over every other event.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state          <= IDLE;
      count_pixel    <= '0;
      count_row      <= '0;
      bus.rama_wren  <= 1'b0;
      bus.ramb_wren  <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.row_parity <= 1'b0;
      bus.row_end    <= 1'b0;
      bus.frame_end  <= 1'b0;
    end else begin
      bus.rama_wren <= 1'b0;
      bus.ramb_wren <= 1'b0;
      bus.row_end   <= 1'b0;
      bus.frame_end <= 1'b0;
      if (bus.frame_start) begin
        // Start or resync: a coincident pixel becomes pixel 0 of row 0.
        state          <= WR_A;
        count_row      <= '0;
        bus.row_parity <= 1'b0;
        if (bus.pix_valid) begin
          bus.rama_wren <= 1'b1;
          bus.wr_addr   <= '0;
          bus.wr_data   <= bus.pix_in;
          count_pixel   <= 11'd1;
        end else begin
          count_pixel   <= '0;
        end
      end else if (bus.pix_valid && (state != IDLE)) begin
        if (state == WR_B) begin
          bus.ramb_wren <= 1'b1;
        end else begin
          bus.rama_wren <= 1'b1;
        end
        // Parity follows the row of the pixel being written, so it flips
        // together with the first write of the next row.
        bus.row_parity <= (state == WR_B);
        bus.wr_addr    <= count_pixel;
        bus.wr_data    <= bus.pix_in;
        if (count_pixel == LAST_PIX) begin
          count_pixel <= '0;
          bus.row_end <= 1'b1;
          if (count_row == LAST_ROW) begin
            bus.frame_end <= 1'b1;
            count_row     <= '0;
            state         <= IDLE;
          end else begin
            count_row <= count_row + 11'd1;
            state     <= (state == WR_A) ? WR_B : WR_A;
          end
        end else begin
          count_pixel <= count_pixel + 11'd1;
        end
      end
    end
  end

`ifdef GEN_RAM_WREN_ERR_EN
  // Sticky error: truncated frame or a pixel arriving outside a frame.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      bus.err_flag <= 1'b0;
    end else if (bus.frame_start && (state != IDLE) &&
                 ((count_pixel != '0) || (count_row != '0))) begin
      bus.err_flag <= 1'b1;
    end else if (!bus.frame_start && bus.pix_valid && (state == IDLE)) begin
      bus.err_flag <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gen_ram_wren.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_ram_wren
// Description : Self-checking bench for gen_ram_wren (12 x 10 frame).
// Revision    : 1.0  initial release
// ============================================================================
module tb_gen_ram_wren;
  localparam int C = 12;
  localparam int R = 10;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  int   checks = 0;
  int   passes = 0;

  gen_ram_wren_if bus();

  gen_ram_wren #(.COLUMN_SIZE(C), .ROW_SIZE(R)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: frame position kept as plain integers.
  bit active;
  int row, col;
  bit m_a, m_b, m_re, m_fe, m_par, m_err;
  int m_addr, m_data;

  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      active = 0; row = 0; col = 0;
      m_a = 0; m_b = 0; m_re = 0; m_fe = 0; m_par = 0; m_err = 0;
      m_addr = 0; m_data = 0;
    end else begin
      m_a = 0; m_b = 0; m_re = 0; m_fe = 0;
      if (bus.frame_start) begin
        if (active && (row != 0 || col != 0)) m_err = 1;
        active = 1; row = 0; col = 0; m_par = 0;
        if (bus.pix_valid) begin
          m_a = 1; m_addr = 0; m_data = int'(bus.pix_in); col = 1;
        end
      end else if (bus.pix_valid) begin
        if (!active) begin
          m_err = 1;
        end else begin
          m_par = (row % 2) == 1;
          if ((row % 2) == 1) m_b = 1; else m_a = 1;
          m_addr = col; m_data = int'(bus.pix_in); col++;
          if (col == C) begin
            col = 0; m_re = 1; row++;
            if (row == R) begin
              m_fe = 1; row = 0; active = 0;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [25:0] got, exp;
    got = {bus.rama_wren, bus.ramb_wren, bus.row_end, bus.frame_end,
           bus.row_parity, bus.wr_addr, bus.wr_data};
    exp = {m_a, m_b, m_re, m_fe, m_par, 11'(m_addr), 10'(m_data)};
    checks++;
    if (got === exp) passes++;
    else $display("FAIL cycle_outputs t=%0t got a/b/re/fe/par=%b%b%b%b%b addr=%0d data=%0h want %b%b%b%b%b addr=%0d data=%0h",
                  $time, got[25], got[24], got[23], got[22], got[21], got[20:10], got[9:0],
                  exp[25], exp[24], exp[23], exp[22], exp[21], exp[20:10], exp[9:0]);
`ifdef GEN_RAM_WREN_ERR_EN
    checks++;
    if (bus.err_flag === m_err) passes++;
    else $display("FAIL cycle_err t=%0t got=%b want=%b", $time, bus.err_flag, m_err);
`endif
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h want=%0h", name, got, exp);
  endtask

  // Apply one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic cyc(input bit fs, input bit v, input logic [9:0] d);
    bus.frame_start = fs;
    bus.pix_valid   = v;
    bus.pix_in      = d;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [9:0] pd(input int r, input int c);
    return 10'((r * 37 + c * 5 + 3) & 1023);
  endfunction

  initial begin
    bus.frame_start = 0; bus.pix_valid = 0; bus.pix_in = '0;
    repeat (2) @(posedge clk);
    #2;
    // Reset held with a stray pixel present
    cyc(0, 1, 10'h5);
    cyc(0, 1, 10'h6);
    lit("reset_wrens", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd0);
    lit("reset_addr", 32'(bus.wr_addr), 32'd0);
    aclr = 1'b1;
    // Stray pixels in IDLE
    cyc(0, 1, 10'h7);
    cyc(0, 1, 10'h8);
    lit("idle_wrens", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd0);
    lit("idle_data", 32'(bus.wr_data), 32'd0);
`ifdef GEN_RAM_WREN_ERR_EN
    lit("idle_err", 32'(bus.err_flag), 32'd1);
`endif
    // Frame 1: row 0 contiguous, row 1 gapped, rows 2..9 contiguous
    cyc(1, 0, 10'h0);
    for (int c = 0; c < C; c++) begin
      cyc(0, 1, pd(0, c));
      if (c == 0) begin
        lit("r0_first_a", 32'(bus.rama_wren), 32'd1);
        lit("r0_first_addr", 32'(bus.wr_addr), 32'd0);
        lit("r0_first_data", 32'(bus.wr_data), 32'd3);
      end
      if (c == C - 1) begin
        lit("r0_last_addr", 32'(bus.wr_addr), 32'd11);
        lit("r0_last_rowend", 32'(bus.row_end), 32'd1);
        lit("r0_last_par", 32'(bus.row_parity), 32'd0);
      end
    end
    for (int c = 0; c < C; c++) begin
      cyc(0, 1, pd(1, c));
      if (c == 0) begin
        lit("r1_first_b", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd1);
        lit("r1_first_par", 32'(bus.row_parity), 32'd1);
      end
      if (c == C - 1) lit("r1_last_rowend", 32'(bus.row_end), 32'd1);
      if (c < C - 1) begin
        cyc(0, 0, 10'h3ff);
        if (c == 0) begin
          lit("gap_wrens", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd0);
          lit("gap_addr_hold", 32'(bus.wr_addr), 32'd0);
          lit("gap_data_hold", 32'(bus.wr_data), 32'd40);
        end
        if (c == 5) lit("gap_no_rowend", 32'(bus.row_end), 32'd0);
      end
    end
    for (int r = 2; r < R; r++)
      for (int c = 0; c < C; c++) begin
        cyc(0, 1, pd(r, c));
        if (r == R - 1 && c == C - 1) begin
          lit("frame_end", {30'd0, bus.row_end, bus.frame_end}, 32'd3);
          lit("last_row_b", 32'(bus.ramb_wren), 32'd1);
          lit("model_idle", 32'(active), 32'd0);
        end
      end
    // Pixels after frame end are ignored
    for (int k = 0; k < 3; k++) cyc(0, 1, 10'(k + 100));
    lit("post_frame_wrens", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd0);
    lit("post_frame_addr", 32'(bus.wr_addr), 32'd11);
    // Clear the sticky state, then a frame with a resync at row 3 pixel 5
    aclr = 1'b0;
    cyc(0, 0, 10'h0);
    aclr = 1'b1;
`ifdef GEN_RAM_WREN_ERR_EN
    lit("err_cleared", 32'(bus.err_flag), 32'd0);
`endif
    cyc(1, 0, 10'h0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < C; c++) cyc(0, 1, pd(r, c));
    for (int c = 0; c < 5; c++) cyc(0, 1, pd(3, c));
    cyc(1, 1, 10'h2a5);
    lit("resync_a", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd2);
    lit("resync_addr", 32'(bus.wr_addr), 32'd0);
    lit("resync_data", 32'(bus.wr_data), 32'h2a5);
    lit("resync_no_end", {30'd0, bus.row_end, bus.frame_end}, 32'd0);
`ifdef GEN_RAM_WREN_ERR_EN
    lit("resync_err", 32'(bus.err_flag), 32'd1);
`endif
    cyc(0, 1, pd(0, 1));
    lit("resync_next_addr", 32'(bus.wr_addr), 32'd1);
    for (int c = 2; c < C; c++) cyc(0, 1, pd(0, c));
    for (int r = 1; r < R; r++)
      for (int c = 0; c < C; c++) begin
        cyc(0, 1, pd(r, c));
        if (r == R - 1 && c == C - 1) lit("resync_frame_end", 32'(bus.frame_end), 32'd1);
      end
    // Async reset mid-row (row 2, pixel 7)
    cyc(1, 0, 10'h0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < C; c++) cyc(0, 1, pd(r, c));
    for (int c = 0; c < 8; c++) cyc(0, 1, pd(2, c));
    lit("pre_reset_a", 32'(bus.rama_wren), 32'd1);
    bus.pix_valid = 0;
    aclr = 1'b0;
    #1;
    lit("async_clear", {bus.rama_wren, bus.ramb_wren, bus.row_parity, bus.wr_addr, bus.wr_data}, 32'd0);
    @(posedge clk);
    #2;
    aclr = 1'b1;
    cyc(1, 1, pd(0, 0));
    lit("restart_a", {30'd0, bus.rama_wren, bus.ramb_wren}, 32'd2);
    lit("restart_addr", 32'(bus.wr_addr), 32'd0);
    cyc(0, 1, pd(0, 1));
    lit("restart_addr1", 32'(bus.wr_addr), 32'd1);
    cyc(0, 0, 10'h0);
    cyc(0, 0, 10'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
